// File: rtl/taxi_axis_rr_merge_pkg.sv
// Shared types and helpers for the round-robin stream merge and its arbiter.
// Arbiter FSM encoding and the index-width helper live here.
package taxi_axis_rr_merge_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_ACTIVE = 1'b1
    } arb_state_t;

    // Port index width, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/taxi_axis_rr_merge_if.sv
// AXI4-Stream bundle with source/sink views; disabled sideband fields keep their
// wires so widths stay fixed, and consumers substitute default values.
interface taxi_axis_if #(
    parameter int DATA_W  = 8,
    parameter int KEEP_EN = (DATA_W > 8),
    parameter int KEEP_W  = (DATA_W + 7) / 8,
    parameter int STRB_EN = 0,
    parameter int LAST_EN = 1,
    parameter int ID_EN   = 0,
    parameter int ID_W    = 8,
    parameter int DEST_EN = 0,
    parameter int DEST_W  = 8,
    parameter int USER_EN = 0,
    parameter int USER_W  = 1
) ();
    logic [DATA_W-1:0] tdata;
    logic [KEEP_W-1:0] tkeep;
    logic [KEEP_W-1:0] tstrb;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [ID_W-1:0]   tid;
    logic [DEST_W-1:0] tdest;
    logic [USER_W-1:0] tuser;

    modport src (
        output tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        input  tready
    );

    modport snk (
        input  tdata, tkeep, tstrb, tvalid, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/taxi_axis_rr_merge_arbiter.sv
// Round-robin arbiter that holds its grant until released by ack; the search
// starts one past the last granted port so every requester is served in turn.
module taxi_rr_arbiter
    import taxi_axis_rr_merge_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [PORTS-1:0]               req,
    input  logic                           ack,
    output logic [clog2_min1(PORTS)-1:0]   grant_idx,
    output logic                           grant_valid
);
    localparam int CL_PORTS = clog2_min1(PORTS);

    arb_state_t          state, state_next;
    logic [CL_PORTS-1:0] grant_next;
    logic [CL_PORTS-1:0] rr_ptr, rr_next;
    logic [CL_PORTS-1:0] winner;
    logic                found;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            grant_idx <= '0;
            rr_ptr    <= CL_PORTS'(PORTS - 1);
        end else begin
            state     <= state_next;
            grant_idx <= grant_next;
            rr_ptr    <= rr_next;
        end
    end

    always_comb begin
        found      = 1'b0;
        winner     = rr_ptr;
        state_next = state;
        grant_next = grant_idx;
        rr_next    = rr_ptr;
        for (int i = 1; i <= PORTS; i++) begin
            if (!found && req[(int'(rr_ptr) + i) % PORTS]) begin
                found  = 1'b1;
                winner = CL_PORTS'((int'(rr_ptr) + i) % PORTS);
            end
        end
        case (state)
            ARB_IDLE: begin
                if (found) begin
                    state_next = ARB_ACTIVE;
                    grant_next = winner;
                    rr_next    = winner;
                end
            end
            ARB_ACTIVE: begin
                if (ack) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    assign grant_valid = (state == ARB_ACTIVE);

endmodule

// File: rtl/taxi_axis_rr_merge.sv
// Frame-aware AXI4-Stream merge: a round-robin arbiter locks one sink per frame
// and a two-register skid stage drives the merged source.
module taxi_axis_rr_merge
    import taxi_axis_rr_merge_pkg::*;
#(
    parameter int   S_COUNT    = 4,
    parameter logic UPDATE_TID = 1'b1
) (
    input  logic     clk,
    input  logic     rst_n,
    taxi_axis_if.snk s_axis [S_COUNT],
    taxi_axis_if.src m_axis
);
    localparam int CL_S_COUNT = clog2_min1(S_COUNT);

    localparam int DATA_W    = m_axis.DATA_W;
    localparam int KEEP_W    = m_axis.KEEP_W;
    localparam int KEEP_EN   = m_axis.KEEP_EN && s_axis[0].KEEP_EN;
    localparam int STRB_EN   = m_axis.STRB_EN && s_axis[0].STRB_EN;
    localparam int LAST_EN   = s_axis[0].LAST_EN;
    localparam int M_LAST_EN = m_axis.LAST_EN;
    localparam int S_ID_EN   = s_axis[0].ID_EN;
    localparam int S_ID_W    = s_axis[0].ID_W;
    localparam int M_ID_EN   = m_axis.ID_EN;
    localparam int M_ID_W    = m_axis.ID_W;
    localparam int DEST_EN   = m_axis.DEST_EN && s_axis[0].DEST_EN;
    localparam int DEST_W    = m_axis.DEST_W;
    localparam int USER_EN   = m_axis.USER_EN && s_axis[0].USER_EN;
    localparam int USER_W    = m_axis.USER_W;
    localparam int BEAT_W    = DATA_W + 2 * KEEP_W + 1 + M_ID_W + DEST_W + USER_W;

    if (S_COUNT < 2 || S_COUNT > 32) begin : g_chk_count
        $fatal(0, "taxi_axis_rr_merge: S_COUNT must be 2..32");
    end
    if (m_axis.DATA_W != s_axis[0].DATA_W) begin : g_chk_data
        $fatal(0, "taxi_axis_rr_merge: DATA_W mismatch");
    end
    if (m_axis.KEEP_W != s_axis[0].KEEP_W) begin : g_chk_keep
        $fatal(0, "taxi_axis_rr_merge: KEEP_W mismatch");
    end
    if (UPDATE_TID && M_ID_EN != 0 && M_ID_W < S_ID_W + CL_S_COUNT) begin : g_chk_id
        $fatal(0, "taxi_axis_rr_merge: m_axis ID_W too narrow for port index");
    end

    logic [S_COUNT-1:0]  s_tvalid;
    logic [DATA_W-1:0]   s_tdata [S_COUNT];
    logic [KEEP_W-1:0]   s_tkeep [S_COUNT];
    logic [KEEP_W-1:0]   s_tstrb [S_COUNT];
    logic                s_tlast [S_COUNT];
    logic [S_ID_W-1:0]   s_tid   [S_COUNT];
    logic [DEST_W-1:0]   s_tdest [S_COUNT];
    logic [USER_W-1:0]   s_tuser [S_COUNT];

    logic [CL_S_COUNT-1:0] grant_idx;
    logic                  grant_valid;
    logic                  skid_ready;

    for (genvar n = 0; n < S_COUNT; n++) begin : g_port
        assign s_tvalid[n] = s_axis[n].tvalid;
        assign s_tdata[n]  = s_axis[n].tdata;
        assign s_tkeep[n]  = KEEP_EN != 0 ? s_axis[n].tkeep : '1;
        assign s_tstrb[n]  = STRB_EN != 0 ? s_axis[n].tstrb : s_tkeep[n];
        assign s_tlast[n]  = LAST_EN != 0 ? s_axis[n].tlast : 1'b1;
        assign s_tid[n]    = S_ID_EN != 0 ? s_axis[n].tid : '0;
        assign s_tdest[n]  = DEST_EN != 0 ? DEST_W'(s_axis[n].tdest) : '0;
        assign s_tuser[n]  = USER_EN != 0 ? USER_W'(s_axis[n].tuser) : '0;
        assign s_axis[n].tready = grant_valid && (grant_idx == CL_S_COUNT'(n)) && skid_ready;
    end

    // Stage p0: granted-port select and handshake
    logic                  in_valid_p0;
    logic                  accept_p0;
    logic                  ack_p0;
    logic                  last_p0;
    logic [M_ID_W-1:0]     tid_p0;
    logic [BEAT_W-1:0]     beat_p0;

    assign in_valid_p0 = grant_valid && s_tvalid[grant_idx];
    assign accept_p0   = in_valid_p0 && skid_ready;
    assign ack_p0      = accept_p0 && s_tlast[grant_idx];
    assign last_p0     = M_LAST_EN != 0 ? s_tlast[grant_idx] : 1'b1;

    if (M_ID_EN == 0) begin : g_tid_off
        assign tid_p0 = '0;
    end else if (UPDATE_TID) begin : g_tid_upd
        assign tid_p0 = M_ID_W'({s_tid[grant_idx], grant_idx});
    end else begin : g_tid_pass
        assign tid_p0 = M_ID_W'(s_tid[grant_idx]);
    end

    assign beat_p0 = {s_tdata[grant_idx], s_tkeep[grant_idx], s_tstrb[grant_idx], last_p0,
                      tid_p0, s_tdest[grant_idx], s_tuser[grant_idx]};

    taxi_rr_arbiter #(
        .PORTS(S_COUNT)
    ) arb_inst (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (s_tvalid),
        .ack        (ack_p0),
        .grant_idx  (grant_idx),
        .grant_valid(grant_valid)
    );

    // Stage p1: output register plus temp register for the skid
    logic              vld_p1;
    logic              tmp_vld_p1;
    logic [BEAT_W-1:0] out_p1;
    logic [BEAT_W-1:0] tmp_p1;
    logic              skid_ready_early;

    // Ready may only stay up if a beat arriving now has somewhere to land.
    assign skid_ready_early = m_axis.tready || (!tmp_vld_p1 && (!vld_p1 || !in_valid_p0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            tmp_vld_p1 <= 1'b0;
            skid_ready <= 1'b0;
        end else begin
            skid_ready <= skid_ready_early;
            if (skid_ready) begin
                if (m_axis.tready || !vld_p1) begin
                    vld_p1 <= in_valid_p0;
                end else begin
                    tmp_vld_p1 <= in_valid_p0;
                end
            end else if (m_axis.tready) begin
                vld_p1     <= tmp_vld_p1;
                tmp_vld_p1 <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (skid_ready) begin
            if (m_axis.tready || !vld_p1) begin
                out_p1 <= beat_p0;
            end else begin
                tmp_p1 <= beat_p0;
            end
        end else if (m_axis.tready) begin
            out_p1 <= tmp_p1;
        end
    end

    assign m_axis.tvalid = vld_p1;
    assign {m_axis.tdata, m_axis.tkeep, m_axis.tstrb, m_axis.tlast,
            m_axis.tid, m_axis.tdest, m_axis.tuser} = out_p1;

endmodule

// File: tb/tb_taxi_axis_rr_merge.sv
// Bench for taxi_axis_rr_merge: one DUT with frame-based grants, one with tlast
// disabled; a scoreboard queue per DUT is filled by the tests and drained by a monitor.
module tb_taxi_axis_rr_merge;

    typedef struct packed {
        logic [3:0] tid;
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic       s_tvalid [2][4];
    logic [7:0] s_tdata  [2][4];
    logic       s_tlast  [2][4];
    logic [1:0] s_tid    [2][4];
    logic       s_tready [2][4];
    logic       m_tready [2];

    beat_t exp_q0[$];
    beat_t exp_q1[$];
    int    log_cyc0[$];
    int    log_cyc1[$];

    taxi_axis_if #(.DATA_W(8), .KEEP_EN(0), .LAST_EN(1), .ID_EN(1), .ID_W(2)) s0_if [4] ();
    taxi_axis_if #(.DATA_W(8), .KEEP_EN(0), .LAST_EN(1), .ID_EN(1), .ID_W(4)) m0_if ();
    taxi_axis_if #(.DATA_W(8), .KEEP_EN(0), .LAST_EN(0), .ID_EN(1), .ID_W(2)) s1_if [4] ();
    taxi_axis_if #(.DATA_W(8), .KEEP_EN(0), .LAST_EN(0), .ID_EN(1), .ID_W(4)) m1_if ();

    for (genvar g = 0; g < 4; g++) begin : g_src
        assign s0_if[g].tvalid = s_tvalid[0][g];
        assign s0_if[g].tdata  = s_tdata[0][g];
        assign s0_if[g].tlast  = s_tlast[0][g];
        assign s0_if[g].tid    = s_tid[0][g];
        assign s0_if[g].tkeep  = '1;
        assign s0_if[g].tstrb  = '1;
        assign s0_if[g].tdest  = '0;
        assign s0_if[g].tuser  = '0;
        assign s_tready[0][g]  = s0_if[g].tready;
        assign s1_if[g].tvalid = s_tvalid[1][g];
        assign s1_if[g].tdata  = s_tdata[1][g];
        assign s1_if[g].tlast  = s_tlast[1][g];
        assign s1_if[g].tid    = s_tid[1][g];
        assign s1_if[g].tkeep  = '1;
        assign s1_if[g].tstrb  = '1;
        assign s1_if[g].tdest  = '0;
        assign s1_if[g].tuser  = '0;
        assign s_tready[1][g]  = s1_if[g].tready;
    end

    assign m0_if.tready = m_tready[0];
    assign m1_if.tready = m_tready[1];

    taxi_axis_rr_merge #(.S_COUNT(4), .UPDATE_TID(1'b1)) dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axis(s0_if),
        .m_axis(m0_if)
    );

    taxi_axis_rr_merge #(.S_COUNT(4), .UPDATE_TID(1'b1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .s_axis(s1_if),
        .m_axis(m1_if)
    );

    task automatic monitor();
        beat_t obs;
        beat_t exp;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (m0_if.tvalid && m_tready[0]) begin
                    obs = '{m0_if.tid, m0_if.tdata, m0_if.tlast};
                    log_cyc0.push_back(cyc);
                    compared++;
                    if (exp_q0.size() == 0) begin
                        mismatched++;
                        $display("FAIL dut0_extra_beat: got tid=%0d data=%02h last=%0b, required no beat",
                                 obs.tid, obs.data, obs.last);
                    end else begin
                        exp = exp_q0.pop_front();
                        if (obs !== exp) begin
                            mismatched++;
                            $display("FAIL dut0_beat: got tid=%0d data=%02h last=%0b, required tid=%0d data=%02h last=%0b",
                                     obs.tid, obs.data, obs.last, exp.tid, exp.data, exp.last);
                        end
                    end
                end
                if (m1_if.tvalid && m_tready[1]) begin
                    obs = '{m1_if.tid, m1_if.tdata, m1_if.tlast};
                    log_cyc1.push_back(cyc);
                    compared++;
                    if (exp_q1.size() == 0) begin
                        mismatched++;
                        $display("FAIL dut1_extra_beat: got tid=%0d data=%02h last=%0b, required no beat",
                                 obs.tid, obs.data, obs.last);
                    end else begin
                        exp = exp_q1.pop_front();
                        if (obs !== exp) begin
                            mismatched++;
                            $display("FAIL dut1_beat: got tid=%0d data=%02h last=%0b, required tid=%0d data=%02h last=%0b",
                                     obs.tid, obs.data, obs.last, exp.tid, exp.data, exp.last);
                        end
                    end
                end
            end
        end
    endtask

    task automatic clear_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) begin
                s_tvalid[d][p] = 1'b0;
                s_tdata[d][p]  = 8'h00;
                s_tlast[d][p]  = 1'b0;
                s_tid[d][p]    = 2'd0;
            end
            m_tready[d] = 1'b1;
        end
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        log_cyc0.delete();
        log_cyc1.delete();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int d, input int p, input logic [7:0] base, input int len,
                              input logic [1:0] sid);
        logic ok;
        int   n;
        for (int i = 0; i < len; i++) begin
            s_tvalid[d][p] = 1'b1;
            s_tdata[d][p]  = base + 8'(i);
            s_tlast[d][p]  = (i == len - 1);
            s_tid[d][p]    = sid;
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 1000) begin
                @(negedge clk);
                ok = s_tready[d][p];
                @(posedge clk);
                #1;
                n++;
            end
            if (!ok) begin
                compared++;
                mismatched++;
                $display("FAIL handshake_timeout: dut%0d port%0d beat %0d got no tready, required tready within 1000 cycles",
                         d, p, i);
                break;
            end
        end
        s_tvalid[d][p] = 1'b0;
        s_tlast[d][p]  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name,
                     exp_q0.size() + exp_q1.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        compared++;
        if (m0_if.tvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_m0_tvalid: got %b, required 0", m0_if.tvalid);
        end
        compared++;
        if (m1_if.tvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_m1_tvalid: got %b, required 0", m1_if.tvalid);
        end
        for (int p = 0; p < 4; p++) begin
            compared++;
            if (s_tready[0][p] !== 1'b0) begin
                mismatched++;
                $display("FAIL reset_s_tready: port %0d got %b, required 0", p, s_tready[0][p]);
            end
        end
        reset_dut();
    endtask

    task automatic test_single();
        int t0;
        int lat;
        reset_dut();
        for (int i = 0; i < 3; i++) exp_q0.push_back('{4'h2, 8'hA1 + 8'(i), (i == 2)});
        t0 = cyc;
        send_frame(0, 2, 8'hA1, 3, 2'd0);
        wait_drain("single");
        lat = (log_cyc0.size() > 0) ? log_cyc0[0] - t0 : -1;
        compared++;
        if (lat !== 2) begin
            mismatched++;
            $display("FAIL single_latency: got %0d cycles, required 2", lat);
        end
        compared++;
        if (log_cyc0.size() !== 3) begin
            mismatched++;
            $display("FAIL single_count: got %0d beats, required 3", log_cyc0.size());
        end
    endtask

    task automatic test_contention();
        int gap_req[5] = '{1, 2, 1, 2, 1};
        reset_dut();
        exp_q0.push_back('{4'h0, 8'h01, 1'b0});
        exp_q0.push_back('{4'h0, 8'h02, 1'b1});
        exp_q0.push_back('{4'h1, 8'h11, 1'b0});
        exp_q0.push_back('{4'h1, 8'h12, 1'b1});
        exp_q0.push_back('{4'h3, 8'h31, 1'b0});
        exp_q0.push_back('{4'h3, 8'h32, 1'b1});
        fork
            send_frame(0, 0, 8'h01, 2, 2'd0);
            send_frame(0, 1, 8'h11, 2, 2'd0);
            send_frame(0, 3, 8'h31, 2, 2'd0);
        join
        wait_drain("contention");
        compared++;
        if (log_cyc0.size() !== 6) begin
            mismatched++;
            $display("FAIL contention_count: got %0d beats, required 6", log_cyc0.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                compared++;
                if (log_cyc0[i+1] - log_cyc0[i] !== gap_req[i]) begin
                    mismatched++;
                    $display("FAIL contention_spacing: beat %0d->%0d got %0d cycles, required %0d",
                             i, i + 1, log_cyc0[i+1] - log_cyc0[i], gap_req[i]);
                end
            end
        end
    endtask

    task automatic test_fairness();
        reset_dut();
        exp_q0.push_back('{4'h0, 8'h41, 1'b0});
        exp_q0.push_back('{4'h0, 8'h42, 1'b1});
        exp_q0.push_back('{4'h1, 8'h51, 1'b0});
        exp_q0.push_back('{4'h1, 8'h52, 1'b1});
        exp_q0.push_back('{4'h0, 8'h43, 1'b0});
        exp_q0.push_back('{4'h0, 8'h44, 1'b1});
        fork
            begin
                send_frame(0, 0, 8'h41, 2, 2'd0);
                send_frame(0, 0, 8'h43, 2, 2'd0);
            end
            send_frame(0, 1, 8'h51, 2, 2'd0);
        join
        wait_drain("fairness");
        compared++;
        if (log_cyc0.size() !== 6) begin
            mismatched++;
            $display("FAIL fairness_count: got %0d beats, required 6", log_cyc0.size());
        end
    endtask

    task automatic test_backpressure();
        bit   pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic done = 1'b0;
        logic a;
        logic b;
        int   k = 0;
        reset_dut();
        for (int i = 0; i < 6; i++) exp_q0.push_back('{4'h0, 8'h61 + 8'(i), (i == 5)});
        fork
            begin
                send_frame(0, 0, 8'h61, 6, 2'd0);
                done = 1'b1;
            end
            begin
                while (!done && k < 200) begin
                    m_tready[0] = pat[k % 6];
                    k++;
                    @(negedge clk);
                    #2;
                    a = s_tready[0][0];
                    m_tready[0] = ~m_tready[0];
                    #1;
                    b = s_tready[0][0];
                    m_tready[0] = ~m_tready[0];
                    compared++;
                    if (a !== b) begin
                        mismatched++;
                        $display("FAIL comb_path: s_tready moved from %b to %b when m_tready toggled, required unchanged",
                                 a, b);
                    end
                    @(posedge clk);
                    #1;
                end
            end
        join
        m_tready[0] = 1'b1;
        wait_drain("backpressure");
        compared++;
        if (log_cyc0.size() !== 6) begin
            mismatched++;
            $display("FAIL backpressure_count: got %0d beats, required 6", log_cyc0.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        logic ok;
        int   n;
        reset_dut();
        exp_q0.push_back('{4'h0, 8'h71, 1'b0});
        for (int i = 0; i < 2; i++) begin
            s_tvalid[0][0] = 1'b1;
            s_tdata[0][0]  = 8'h71 + 8'(i);
            s_tlast[0][0]  = 1'b0;
            s_tid[0][0]    = 2'd0;
            ok = 1'b0;
            n  = 0;
            while (!ok && n < 100) begin
                @(negedge clk);
                ok = s_tready[0][0];
                @(posedge clk);
                #1;
                n++;
            end
            if (!ok) begin
                compared++;
                mismatched++;
                $display("FAIL midreset_handshake: beat %0d got no tready, required tready within 100 cycles", i);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        compared++;
        if (m0_if.tvalid !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_tvalid: got %b, required 0 without a clock edge", m0_if.tvalid);
        end
        compared++;
        if (s_tready[0][0] !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_tready: got %b, required 0", s_tready[0][0]);
        end
        compared++;
        if (exp_q0.size() !== 0) begin
            mismatched++;
            $display("FAIL midreset_partial: got %0d pre-reset beats unseen, required 0", exp_q0.size());
        end
        s_tvalid[0][0] = 1'b0;
        exp_q0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q0.push_back('{4'h0, 8'h81, 1'b0});
        exp_q0.push_back('{4'h0, 8'h82, 1'b1});
        send_frame(0, 0, 8'h81, 2, 2'd0);
        wait_drain("midreset");
    endtask

    task automatic test_last_en_off();
        reset_dut();
        for (int i = 0; i < 3; i++) begin
            exp_q1.push_back('{4'h0, 8'h90 + 8'(i), 1'b1});
            exp_q1.push_back('{4'h1, 8'hA0 + 8'(i), 1'b1});
        end
        fork
            send_frame(1, 0, 8'h90, 3, 2'd0);
            send_frame(1, 1, 8'hA0, 3, 2'd0);
        join
        wait_drain("last_en_off");
        compared++;
        if (log_cyc1.size() !== 6) begin
            mismatched++;
            $display("FAIL noLast_count: got %0d beats, required 6", log_cyc1.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                compared++;
                if (log_cyc1[i+1] - log_cyc1[i] !== 2) begin
                    mismatched++;
                    $display("FAIL noLast_spacing: beat %0d->%0d got %0d cycles, required 2",
                             i, i + 1, log_cyc1[i+1] - log_cyc1[i]);
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation got no finish by 500000, required earlier finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_contention();
        test_fairness();
        test_backpressure();
        test_reset_mid_frame();
        test_last_en_off();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
